// File: rtl/sched_pkg.sv
// Shared definitions for the nested-loop scheduler: default widths and FSM states.
package sched_pkg;

  localparam int CNT_BITS  = 10;
  localparam int ADDR_BITS = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/loop_cnt.sv
// Single-level loop counter: counts 0..final_number and wraps on the enable
// that finds it at (or beyond) the final value. last flags that condition.
module loop_cnt #(
  parameter int W = sched_pkg::CNT_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] final_number,
  output logic [W-1:0] q,
  output logic         last
);

  logic [W-1:0] r_q;

  // An out-of-range index is treated as last, so the loop always terminates.
  assign last = (r_q >= final_number);
  assign q    = r_q;

  // Index register: clear dominates, otherwise step or wrap on enable.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (!reset) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (enable) begin
      r_q <= last ? '0 : r_q + 1'b1;
    end
  end

endmodule

// File: rtl/loop_sched_ctrl.sv
// Three-level (row / col / ch) loop scheduler emitting one beat per accepted
// valid/ready handshake. Linear address is built from two accumulators plus
// the channel index, so no multiplier is needed.
module loop_sched_ctrl #(
  parameter int CNT_BITS  = sched_pkg::CNT_BITS,
  parameter int ADDR_BITS = sched_pkg::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [CNT_BITS-1:0]  cfg_ch_final,
  input  logic [CNT_BITS-1:0]  cfg_col_final,
  input  logic [CNT_BITS-1:0]  cfg_row_final,
  input  logic [ADDR_BITS-1:0] cfg_row_stride,
  input  logic                 abort,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [CNT_BITS-1:0]  out_ch,
  output logic [CNT_BITS-1:0]  out_col,
  output logic [CNT_BITS-1:0]  out_row,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  import sched_pkg::state_e;
  import sched_pkg::S_IDLE;
  import sched_pkg::S_RUN;
  import sched_pkg::S_DONE;

  state_e r_state;
  state_e w_state_nxt;

  logic [CNT_BITS-1:0]  r_ch_final;
  logic [CNT_BITS-1:0]  r_col_final;
  logic [CNT_BITS-1:0]  r_row_final;
  logic [ADDR_BITS-1:0] r_row_stride;
  logic [ADDR_BITS-1:0] r_col_base;
  logic [ADDR_BITS-1:0] r_row_base;
  logic                 r_first;

  logic [CNT_BITS-1:0]  w_ch;
  logic [CNT_BITS-1:0]  w_col;
  logic [CNT_BITS-1:0]  w_row;
  logic                 w_ch_last;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_xfer;
  logic                 w_start;
  logic                 w_clear;
  logic [ADDR_BITS-1:0] w_col_step;

  assign w_xfer     = out_valid & out_ready;
  assign w_start    = (r_state == S_IDLE) & cfg_start & ~abort;
  // Counters only move in RUN; outside it (or on abort) they are held at zero.
  assign w_clear    = abort | (r_state != S_RUN);
  assign w_col_step = ADDR_BITS'(r_ch_final) + 1'b1;

  loop_cnt #(.W(CNT_BITS)) u_ch_cnt (
    .clk          (clk),
    .reset        (reset),
    .enable       (w_xfer),
    .clear        (w_clear),
    .final_number (r_ch_final),
    .q            (w_ch),
    .last         (w_ch_last)
  );

  loop_cnt #(.W(CNT_BITS)) u_col_cnt (
    .clk          (clk),
    .reset        (reset),
    .enable       (w_xfer & w_ch_last),
    .clear        (w_clear),
    .final_number (r_col_final),
    .q            (w_col),
    .last         (w_col_last)
  );

  loop_cnt #(.W(CNT_BITS)) u_row_cnt (
    .clk          (clk),
    .reset        (reset),
    .enable       (w_xfer & w_ch_last & w_col_last),
    .clear        (w_clear),
    .final_number (r_row_final),
    .q            (w_row),
    .last         (w_row_last)
  );

  // Next-state logic: abort overrides everything; RUN ends on the final transfer.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_nxt unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (cfg_start) w_state_nxt = S_RUN;
        S_RUN:   if (w_xfer && out_last) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Job configuration is captured only on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ch_final   <= '0;
      r_col_final  <= '0;
      r_row_final  <= '0;
      r_row_stride <= '0;
    end else if (w_start) begin
      r_ch_final   <= cfg_ch_final;
      r_col_final  <= cfg_col_final;
      r_row_final  <= cfg_row_final;
      r_row_stride <= cfg_row_stride;
    end
  end

  // Address accumulators track col and row bases alongside the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col_base <= '0;
      r_row_base <= '0;
    end else if (w_clear) begin
      r_col_base <= '0;
      r_row_base <= '0;
    end else if (w_xfer && w_ch_last) begin
      if (w_col_last) begin
        r_col_base <= '0;
        r_row_base <= w_row_last ? '0 : r_row_base + r_row_stride;
      end else begin
        r_col_base <= r_col_base + w_col_step;
      end
    end
  end

  // First-beat flag: armed by start, dropped by the first transfer or abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_first <= 1'b0;
    else if (abort)   r_first <= 1'b0;
    else if (w_start) r_first <= 1'b1;
    else if (w_xfer)  r_first <= 1'b0;
  end

  assign out_valid = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign out_ch    = w_ch;
  assign out_col   = w_col;
  assign out_row   = w_row;
  assign out_addr  = r_row_base + r_col_base + ADDR_BITS'(w_ch);
  assign out_first = r_first & out_valid;
  assign out_last  = w_ch_last & w_col_last & w_row_last & out_valid;

endmodule

// File: tb/tb_loop_sched_ctrl.sv
// Self-checking bench for loop_sched_ctrl. A queue-based job model predicts
// every beat from nested row/col/ch loops; a negedge monitor compares the DUT
// against it each cycle, and directed scenarios pin literal expectations.
module tb_loop_sched_ctrl;

  localparam int CB = 10;
  localparam int AB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start = 1'b0;
  logic [CB-1:0] cfg_ch_final = '0;
  logic [CB-1:0] cfg_col_final = '0;
  logic [CB-1:0] cfg_row_final = '0;
  logic [AB-1:0] cfg_row_stride = '0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [CB-1:0] out_ch;
  logic [CB-1:0] out_col;
  logic [CB-1:0] out_row;
  logic [AB-1:0] out_addr;
  logic          out_first;
  logic          out_last;
  logic          busy;
  logic          done;

  loop_sched_ctrl #(.CNT_BITS(CB), .ADDR_BITS(AB)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_ch_final   (cfg_ch_final),
    .cfg_col_final  (cfg_col_final),
    .cfg_row_final  (cfg_row_final),
    .cfg_row_stride (cfg_row_stride),
    .abort          (abort),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_ch         (out_ch),
    .out_col        (out_col),
    .out_row        (out_row),
    .out_addr       (out_addr),
    .out_first      (out_first),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned ch;
    int unsigned col;
    int unsigned row;
    int unsigned addr;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mb;
  int unsigned acc_addr[$];
  int unsigned exp1[12] = '{0, 1, 2, 3, 4, 5, 16, 17, 18, 19, 20, 21};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_state  = 0;   // 0 idle, 1 running, 2 done pulse
  int m_idx    = 0;
  int last_cyc = -1;
  int done_cyc = -2;
  int done_cnt = 0;
  int busy_cnt = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected job: every (row, col, ch) in loop order, address by plain arithmetic.
  function automatic void build_job(input int chf, input int colf, input int rowf,
                                    input int unsigned stride);
    beat_t b;
    exp_q.delete();
    for (int r = 0; r <= rowf; r++)
      for (int c = 0; c <= colf; c++)
        for (int h = 0; h <= chf; h++) begin
          b.ch   = h;
          b.col  = c;
          b.row  = r;
          b.addr = (r * stride + c * (chf + 1) + h) & 32'hFFFF;
          exp_q.push_back(b);
        end
  endfunction

  // Per-cycle compare against the model, then advance the model on the
  // inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_addr", {16'd0, out_addr}, 32'd0);
      m_state = 0;
      exp_q.delete();
    end else begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_state == 1});
      check("busy", {31'd0, busy}, {31'd0, m_state == 1});
      check("done", {31'd0, done}, {31'd0, m_state == 2});
      if (m_state == 1 && exp_q.size() > 0) begin
        mb = exp_q[0];
        check("out_ch", {22'd0, out_ch}, mb.ch);
        check("out_col", {22'd0, out_col}, mb.col);
        check("out_row", {22'd0, out_row}, mb.row);
        check("out_addr", {16'd0, out_addr}, mb.addr);
        check("out_first", {31'd0, out_first}, {31'd0, m_idx == 0});
        check("out_last", {31'd0, out_last}, {31'd0, exp_q.size() == 1});
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (abort) begin
        m_state = 0;
        exp_q.delete();
      end else begin
        case (m_state)
          0: if (cfg_start) begin
               build_job(cfg_ch_final, cfg_col_final, cfg_row_final, cfg_row_stride);
               m_idx   = 0;
               m_state = 1;
             end
          1: if (out_ready) begin
               acc_addr.push_back(out_addr);
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               m_idx++;
               if (exp_q.size() == 0) begin
                 m_state  = 2;
                 last_cyc = cyc;
               end
             end
          default: m_state = 0;
        endcase
      end
    end
  end

  // Downstream ready: constantly high, or a random 1/0 pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic clear_log();
    acc_addr.delete();
    done_cnt = 0;
    busy_cnt = 0;
    last_cyc = -1;
    done_cyc = -2;
  endtask

  // Pulse cfg_start for one cycle, then scramble the cfg inputs so a job that
  // failed to latch them would visibly diverge.
  task automatic start_job(input int chf, input int colf, input int rowf, input int unsigned stride);
    @(posedge clk);
    #1;
    cfg_ch_final   = CB'(chf);
    cfg_col_final  = CB'(colf);
    cfg_row_final  = CB'(rowf);
    cfg_row_stride = AB'(stride);
    cfg_start      = 1'b1;
    @(posedge clk);
    #1;
    cfg_start      = 1'b0;
    cfg_ch_final   = CB'($urandom_range(0, 7));
    cfg_col_final  = CB'($urandom_range(0, 7));
    cfg_row_final  = CB'($urandom_range(0, 7));
    cfg_row_stride = AB'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_state != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_state != 0) check("job_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_beats"}, acc_addr.size(), 32'd12);
    for (int i = 0; i < 12; i++)
      if (i < acc_addr.size()) check($sformatf("%s_addr%0d", tag, i), acc_addr[i], exp1[i]);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_first", {31'd0, out_first}, 32'd0);
    check("reset_row", {22'd0, out_row}, 32'd0);
    reset = 1'b1;

    // Basic 12-beat job, ready held high; a start during DONE is ignored.
    clear_log();
    start_job(1, 2, 1, 16);
    n = 0;
    while (!(out_valid && out_last) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    cfg_ch_final = '0;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    wait_idle(20);
    check("start_in_done_ignored", {31'd0, out_valid}, 32'd0);
    check_seq("job1");
    check("job1_done_lat", done_cyc - last_cyc, 32'd1);
    check("job1_done_cnt", done_cnt, 32'd1);
    check("job1_busy_cyc", busy_cnt, 32'd12);

    // All finals zero: single beat that is both first and last.
    clear_log();
    start_job(0, 0, 0, 0);
    check("zero_first", {31'd0, out_first}, 32'd1);
    check("zero_last", {31'd0, out_last}, 32'd1);
    wait_idle(20);
    check("zero_beats", acc_addr.size(), 32'd1);
    if (acc_addr.size() > 0) check("zero_addr", acc_addr[0], 32'd0);
    check("zero_busy_cyc", busy_cnt, 32'd1);
    check("zero_done_lat", done_cyc - last_cyc, 32'd1);

    // Same job with random back-pressure.
    clear_log();
    rand_ready = 1'b1;
    start_job(1, 2, 1, 16);
    wait_idle(500);
    rand_ready = 1'b0;
    check_seq("stall");

    // Start pulse with different finals mid-run is ignored.
    clear_log();
    start_job(1, 2, 1, 16);
    repeat (3) @(posedge clk);
    #1;
    cfg_ch_final = 3;
    cfg_col_final = 3;
    cfg_row_final = 3;
    cfg_row_stride = 99;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    wait_idle(100);
    check_seq("midstart");

    // Abort right after beat 5 transfers.
    clear_log();
    start_job(1, 2, 1, 16);
    n = 0;
    while (acc_addr.size() < 6 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_first", {31'd0, out_first}, 32'd0);
    check("abort_ch", {22'd0, out_ch}, 32'd0);
    check("abort_addr", {16'd0, out_addr}, 32'd0);
    check("abort_beats", acc_addr.size(), 32'd6);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, 32'd0);
    // Abort together with start in IDLE: the job must not begin.
    @(posedge clk);
    #1;
    abort = 1'b1;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    cfg_start = 1'b0;
    check("abort_wins", {31'd0, out_valid}, 32'd0);
    clear_log();
    start_job(1, 2, 1, 16);
    check("restart_row", {22'd0, out_row}, 32'd0);
    check("restart_col", {22'd0, out_col}, 32'd0);
    wait_idle(100);
    check_seq("restart");

    // Asynchronous reset in the middle of a job.
    clear_log();
    start_job(1, 2, 1, 16);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_last", {31'd0, out_last}, 32'd0);
    check("midrst_ch", {22'd0, out_ch}, 32'd0);
    check("midrst_addr", {16'd0, out_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("midrst_no_done", done_cnt, 32'd0);
    clear_log();
    start_job(0, 1, 2, 7);
    check("postrst_valid", {31'd0, out_valid}, 32'd1);
    check("postrst_addr", {16'd0, out_addr}, 32'd0);
    wait_idle(100);

    // Row base wraps modulo 2^16.
    clear_log();
    start_job(1, 1, 2, 32'hFFF0);
    wait_idle(100);
    check("wrap_beats", acc_addr.size(), 32'd12);
    if (acc_addr.size() == 12) begin
      check("wrap_row0", acc_addr[0], 32'h0000);
      check("wrap_row1", acc_addr[4], 32'hFFF0);
      check("wrap_row2", acc_addr[8], 32'hFFE0);
      check("wrap_tail", acc_addr[11], 32'hFFE3);
    end

    // Random jobs, all checked by the model.
    for (int j = 0; j < 8; j++) begin
      clear_log();
      rand_ready = 1'($urandom_range(0, 1));
      start_job($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      wait_idle(2000);
      check($sformatf("rand%0d_done_cnt", j), done_cnt, 32'd1);
    end
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_sched_ctrl.md
Name: loop_sched_ctrl

Overview:
- Three-level nested-loop scheduler for the conv tile datapath. Channel is the innermost loop, then column, then row.
- Built from three single-level loop counters with start/final/last semantics.
- Issues one (row, col, ch, addr) beat per accepted handshake to the address/PE-load stage. Reports busy/done to the top-level sequencer.
- Address is produced with accumulators only; no multipliers.

Parameters:
- CNT_BITS, 10, width of each loop index and each loop final value
- ADDR_BITS, 16, width of generated linear address and of the row stride

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); deassertion is synchronous to clk upstream
- cfg_start  in  1  single-cycle start pulse; honoured only in IDLE
- cfg_ch_final  in  CNT_BITS  last channel index (inclusive)
- cfg_col_final  in  CNT_BITS  last column index (inclusive)
- cfg_row_final  in  CNT_BITS  last row index (inclusive)
- cfg_row_stride  in  ADDR_BITS  address increment per row
- abort  in  1  synchronous kill; highest priority after reset
- out_ready  in  1  downstream accepts the current beat
- out_valid  out  1  beat present
- out_ch / out_col / out_row  out  CNT_BITS each  current loop indices
- out_addr  out  ADDR_BITS  row_base + col_base + ch
- out_first  out  1  high on the first beat of the job
- out_last  out  1  high on the final beat of the job
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (reset == 0): state = IDLE. All outputs are 0, all counters and accumulators are 0, latched config is 0.
- States and transitions:
  - IDLE: on cfg_start, latch all cfg_* and go to RUN.
  - RUN: stays until the final beat is accepted, then goes to DONE.
  - DONE: lasts exactly one cycle with done = 1, then returns to IDLE.
- Config changes after the start cycle have no effect on a running job.
- Latency: cfg_start sampled at edge t → out_valid = 1 from edge t+1 with ch = col = row = 0, addr = 0, out_first = 1.
- Handshake (valid/ready):
  - A beat transfers when out_valid & out_ready at a rising edge.
  - While out_valid = 1 and out_ready = 0, all payload outputs are held stable.
  - out_valid never drops in RUN before the final transfer.
- Advance on each transfer:
  - ch < ch_final: ch += 1.
  - Otherwise ch = 0, and col advances the same way; col_base += ch_final + 1.
  - At col wrap: col = 0, col_base = 0, row += 1, row_base += row_stride.
- out_last = (ch == ch_final) & (col == col_final) & (row == row_final) & out_valid.
- Transfer with out_last → out_valid = 0 at the next edge; state DONE, done = 1 for that one cycle.
- Arithmetic:
  - Index compares use >= final, so an out-of-range index is treated as last.
  - Address accumulators wrap modulo 2^ADDR_BITS; no saturation or error flag.
- Boundary conditions:
  - All finals = 0: exactly one beat, with out_first = out_last = 1.
  - cfg_start during RUN or DONE is ignored, with no side effects.
  - A new cfg_start is first accepted the cycle after done.
  - abort in any state → IDLE at the next edge. out_valid, busy and out_first/out_last go to 0; done is NOT asserted; counters are cleared.
  - abort and cfg_start in the same IDLE cycle: abort wins and the job does not start.
  - Reset mid-job: immediate asynchronous return to the reset values; no done.
- busy = 1 exactly in RUN; busy and done are never high together.

Decomposition:
- Shared package `sched_pkg`:
  - State encoding localparams S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2.
  - Default widths CNT_BITS and ADDR_BITS.
- One sub-module `loop_cnt`:
  - Ports: clk, reset, enable, clear, final_number; outputs q and last.
  - Behaviour: count 0..final and wrap to 0 on enable when q >= final; clear forces 0.
  - Instantiated three times.
- Enables are chained:
  - ch: enable = transfer.
  - col: enable = transfer & ch_last.
  - row: enable = transfer & ch_last & col_last.

Test Plan:
- Finals ch = 1, col = 2, row = 1, stride = 16, out_ready held 1 → 12 beats. addr sequence 0,1,2,3,4,5,16,17,18,19,20,21. out_first only on beat 0, out_last only on beat 11, done pulse 1 cycle after beat 11.
- All finals 0 → single beat (0,0,0, addr 0) with first = last = 1. busy high for 1 cycle; done on the next cycle.
- Same job as the first scenario, out_ready toggling 1/0 randomly → payload stable during stalls, identical 12-beat sequence, no dropped or duplicated beats.
- cfg_start pulsed mid-RUN with different finals → ignored; original sequence completes unchanged.
- abort asserted after beat 5 of the first job → out_valid and busy 0 next cycle, no done. A new cfg_start then restarts at (0,0,0).
- reset driven to 0 mid-job and released → all outputs 0 immediately; the next cfg_start yields first beat addr 0.
- stride = 0xFFF0 with row_final = 2 → row_base wraps modulo 2^16 (0x0000, 0xFFF0, 0xFFE0).
